// File: rtl/seq_det_param.sv
// seq_det_param -- serial pattern detector with a runtime-loadable pattern.
//
// Shifts accepted bits (en=1) into a history register and compares the newest
// len bits against the active pattern. Pattern, length and overlap mode are
// loaded with load; a match gives a one-cycle registered pulse on z and bumps
// a saturating match counter.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset (overrides everything)
//   x         in   serial data bit
//   en        in   x is consumed only on edges with en=1
//   load      in   latch pat_i/len_i/ovl_i; the bit offered on that edge is dropped
//   pat_i     in   new pattern, pat_i[len-1] is received first, pat_i[0] last
//   len_i     in   new pattern length
//   ovl_i     in   new overlap mode (1 = overlapping matches allowed)
//   clr_cnt   in   clear match counter (a same-edge match leaves it at 1)
//   z         out  registered one-cycle match pulse
//   match_cnt out  saturating match count
//   cfg_err   out  active length is 0 or larger than MAX_LEN
module seq_det_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_1010,
    parameter int                 DEF_LEN = 4,
    parameter bit                 DEF_OVL = 1'b0,
    localparam int                LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               en,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat_i,
    input  logic [LW-1:0]      len_i,
    input  logic               ovl_i,
    input  logic               clr_cnt,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam logic [LW-1:0]    LEN_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0]    LEN_DEF = LW'(DEF_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    function automatic logic len_bad(input logic [LW-1:0] l);
        return (l == '0) || (l > LEN_MAX);
    endfunction

    logic [MAX_LEN-1:0] hist, pat, hist_next, mask;
    logic [LW-1:0]      fill, len, fill_next;
    logic               ovl, match;

    // Only the low len bits of the pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    always_comb begin
        hist_next = MAX_LEN'({hist, x});
        fill_next = (fill == LEN_MAX) ? fill : fill + 1'b1;
        // fill_next >= len guarantees every compared bit arrived after the
        // last reset/load/non-overlap match, so stale history never matches.
        match = en && !load && !cfg_err && (fill_next >= len) &&
                (((hist_next ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            pat       <= DEF_PAT;
            len       <= LEN_DEF;
            ovl       <= DEF_OVL;
            cfg_err   <= len_bad(LEN_DEF);
        end else begin
            z <= 1'b0;
            if (load) begin
                pat     <= pat_i;
                len     <= len_i;
                ovl     <= ovl_i;
                fill    <= '0;
                cfg_err <= len_bad(len_i);
            end else if (en) begin
                hist <= hist_next;
                // Non-overlap restarts the fill so the next match needs len fresh bits.
                fill <= (match && !ovl) ? '0 : fill_next;
                z    <= match;
            end

            if (clr_cnt)
                match_cnt <= CNT_W'(match);
            else if (match && match_cnt != CNT_SAT)
                match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios plus a randomized run against a
// queue-based reference model of the detector behaviour.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1, x = 1'b0, en = 1'b0, load = 1'b0, ovl_i = 1'b0, clr_cnt = 1'b0;
    logic [7:0] pat_i = '0;
    logic [3:0] len_i = '0;
    logic       z, cfg_err;
    logic [7:0] match_cnt;

    logic       rst2 = 1'b1, x2 = 1'b0, en2 = 1'b0, load2 = 1'b0, ovl2 = 1'b0, clr2 = 1'b0;
    logic [7:0] pat2 = '0;
    logic [3:0] len2 = '0;
    logic       z2, err2;
    logic [1:0] cnt2;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_det_param dut (
        .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pat_i(pat_i),
        .len_i(len_i), .ovl_i(ovl_i), .clr_cnt(clr_cnt), .z(z),
        .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    seq_det_param #(.CNT_W(2), .DEF_PAT(8'h01), .DEF_LEN(1), .DEF_OVL(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .x(x2), .en(en2), .load(load2), .pat_i(pat2),
        .len_i(len2), .ovl_i(ovl2), .clr_cnt(clr2), .z(z2),
        .match_cnt(cnt2), .cfg_err(err2)
    );

    // Reference model: the bits accepted since the last restart point, newest last.
    bit       m_q[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_cnt;
    bit       exp_z, exp_err;

    task automatic step(input bit r, input bit e, input bit l, input bit c, input bit xb);
        bit hit;
        rst = r; en = e; load = l; clr_cnt = c; x = xb;
        @(posedge clk);
        hit = 0;
        exp_z = 0;
        if (r) begin
            m_q.delete(); m_pat = 8'b1010; m_len = 4; m_ovl = 0; m_cnt = 0;
            exp_err = 0;
        end else begin
            if (l) begin
                m_pat = pat_i; m_len = int'(len_i); m_ovl = ovl_i; m_q.delete();
                exp_err = (m_len == 0) || (m_len > 8);
            end else if (e) begin
                m_q.push_back(xb);
                if (m_q.size() > 8) void'(m_q.pop_front());
                if (!exp_err && m_q.size() >= m_len) begin
                    hit = 1;
                    for (int k = 0; k < m_len; k++)
                        if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 0;
                end
                if (hit) begin
                    exp_z = 1;
                    if (!m_ovl) m_q.delete();
                end
            end
            if (c) m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < 255) m_cnt++;
        end
        #1;
        rst = 0; load = 0; clr_cnt = 0;
    endtask

    task automatic step2(input bit r, input bit e, input bit c, input bit xb);
        rst2 = r; en2 = e; clr2 = c; x2 = xb;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z got %b want 0", z); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cfg_err); end
    endtask

    // Eleven-bit stimulus 1 1 0 1 0 1 0 1 0 1 0 (first bit is index 0).
    task automatic run_stream(input string name, input bit [10:0] want_z);
        bit [10:0] bits = 11'b11010101010;
        for (int i = 0; i < 11; i++) begin
            step(0, 1, 0, 0, bits[10 - i]);
            checks++;
            if (z !== want_z[10 - i] || z !== exp_z) begin
                errors++;
                $display("FAIL %s_z bit%0d got %b want %b", name, i + 1, z, want_z[10 - i]);
            end
        end
    endtask

    task automatic test_nonoverlap();
        step(1, 0, 0, 0, 0);
        run_stream("nonovl", 11'b00001000100);
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL nonovl_cnt got %0d want 2", match_cnt); end
    endtask

    task automatic test_overlap();
        pat_i = 8'b1010; len_i = 4'd4; ovl_i = 1'b1;
        step(0, 1, 1, 1, 1);  // load + clear together
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL ovl_loadclr_cnt got %0d want 0", match_cnt); end
        run_stream("ovl", 11'b00001010101);
        checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL ovl_cnt got %0d want 4", match_cnt); end
    endtask

    task automatic test_bubbles();
        bit [3:0] p = 4'b1010;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, p[3 - i]);
            checks++;
            if (z !== (i == 3)) begin errors++; $display("FAIL bubble_z bit%0d got %b want %b", i + 1, z, i == 3); end
            step(0, 0, 0, 0, 1'($urandom));
            checks++;
            if (z !== 1'b0) begin errors++; $display("FAIL bubble_gap%0d_z got %b want 0", i + 1, z); end
        end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL bubble_cnt got %0d want 1", match_cnt); end
    endtask

    task automatic test_reset_mid();
        pat_i = 8'b101; len_i = 4'd3; ovl_i = 1'b1;
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL rstmid_z got %b want 0", z); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", match_cnt); end
        // Defaults are back: 1 0 1 0 fresh bits match (earlier 1 0 1 does not count).
        step(0, 1, 0, 0, 1); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 1);
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL rstmid_pre_z got %b want 0", z); end
        step(0, 1, 0, 0, 0);
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL rstmid_def_z got %b want 1", z); end
    endtask

    task automatic test_cfg_err();
        bit [4:0] want = 5'b00111;
        pat_i = 8'h00; len_i = 4'd0; ovl_i = 1'b0;
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfgerr_len0 got %b want 1", cfg_err); end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 1'($urandom));
            checks++; if (z !== 1'b0) begin errors++; $display("FAIL cfgerr_z%0d got %b want 0", i, z); end
        end
        pat_i = 8'b111; len_i = 4'd3; ovl_i = 1'b1;
        step(0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfgerr_len3 got %b want 0", cfg_err); end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 1);
            checks++;
            if (z !== want[4 - i]) begin errors++; $display("FAIL cfg111_z bit%0d got %b want %b", i + 1, z, want[4 - i]); end
        end
        checks++; if (match_cnt !== 8'd3) begin errors++; $display("FAIL cfg111_cnt got %0d want 3", match_cnt); end
    endtask

    task automatic test_saturate();
        int want[5] = '{1, 2, 3, 3, 3};
        step2(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step2(0, 1, 0, 1);
            checks++;
            if (cnt2 !== 2'(want[i]) || z2 !== 1'b1) begin
                errors++; $display("FAIL sat_cnt%0d got %0d/z%b want %0d/z1", i + 1, cnt2, z2, want[i]);
            end
        end
        step2(0, 1, 1, 1);
        checks++; if (cnt2 !== 2'd1) begin errors++; $display("FAIL sat_clr_match got %0d want 1", cnt2); end
        step2(0, 1, 1, 0);
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr_nomatch got %0d want 0", cnt2); end
        step2(1, 0, 0, 0);
    endtask

    task automatic test_random();
        bit r, l, e, c;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 149) == 0);
            l = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 39) == 0);
            if (l) begin
                pat_i = 8'($urandom);
                len_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 4));
                ovl_i = 1'($urandom);
            end
            step(r, e, l, c, 1'($urandom));
            checks++;
            if (z !== exp_z || match_cnt !== 8'(m_cnt) || cfg_err !== exp_err) begin
                errors++;
                $display("FAIL rand%0d z/cnt/err got %b/%0d/%b want %b/%0d/%b",
                         i, z, match_cnt, cfg_err, exp_z, m_cnt, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_bubbles();
        test_reset_mid();
        test_cfg_err();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
